sprite_scheduler: RTL and testbench

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

---
 rtl/sprite_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Sprite placement scheduler: double-buffered per-sprite x/y/en banks,
// frame-synchronous commit, and a 2-stage hit/priority/address pipeline.
// Ports: pixel_clk_in clock, rst_in async active-high reset,
//   hcount_in/vcount_in scan position, new_frame_in frame pulse,
//   cfg_valid_in/cfg_ready_out/cfg_idx_in/cfg_x_in/cfg_y_in/cfg_en_in
//   placement writes into the shadow bank,
//   image_addr_out/in_sprite_out/sprite_idx_out winning-sprite result,
//   collision_out sticky overlap flag.
// Build option: define SPRITE_COLLISION_DETECT_EN to enable collision
//   detection; otherwise collision_out is tied to 0.
module sprite_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int WIDTH       = 73,
  parameter int HEIGHT      = 9
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             new_frame_in,
  input  logic                             cfg_valid_in,
  output logic                             cfg_ready_out,
  input  logic [$clog2(NUM_SPRITES)-1:0]   cfg_idx_in,
  input  logic [10:0]                      cfg_x_in,
  input  logic [9:0]                       cfg_y_in,
  input  logic                             cfg_en_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]  image_addr_out,
  output logic                             in_sprite_out,
  output logic [$clog2(NUM_SPRITES)-1:0]   sprite_idx_out,
  output logic                             collision_out
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int AW = $clog2(WIDTH*HEIGHT);

  typedef enum logic {
    ARMED  = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t state, state_nx;
  logic   commit;
  logic   cfg_fire;

  logic [10:0] sh_x  [NUM_SPRITES];
  logic [9:0]  sh_y  [NUM_SPRITES];
  logic        sh_en [NUM_SPRITES];
  logic [10:0] ac_x  [NUM_SPRITES];
  logic [9:0]  ac_y  [NUM_SPRITES];
  logic        ac_en [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit_c;
  logic [10:0]            hoff_c [NUM_SPRITES];
  logic [9:0]             voff_c [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit_s1;
  logic [10:0]            hoff_s1 [NUM_SPRITES];
  logic [9:0]             voff_s1 [NUM_SPRITES];

  logic          sel_hit;
  logic [IW-1:0] sel_idx;
  logic [10:0]   sel_h;
  logic [9:0]    sel_v;
  logic [20:0]   addr_full;

  // FSM: state register
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= ARMED;
    else        state <= state_nx;
  end

  // FSM: next state (new_frame_in is ignored in COMMIT)
  always_comb begin
    state_nx = state;
    unique case (state)
      ARMED:  if (new_frame_in) state_nx = COMMIT;
      COMMIT: state_nx = ARMED;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready_out = (state == ARMED);
    commit        = (state == COMMIT);
  end

  assign cfg_fire = cfg_valid_in && cfg_ready_out;

  // Shadow bank; out-of-range indices are accepted but dropped.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        sh_en[i] <= 1'b0;
      end
    end else if (cfg_fire && (int'(cfg_idx_in) < NUM_SPRITES)) begin
      sh_x[cfg_idx_in]  <= cfg_x_in;
      sh_y[cfg_idx_in]  <= cfg_y_in;
      sh_en[cfg_idx_in] <= cfg_en_in;
    end
  end

  // Active bank follows shadow only in the COMMIT cycle.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        ac_x[i]  <= '0;
        ac_y[i]  <= '0;
        ac_en[i] <= 1'b0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        ac_x[i]  <= sh_x[i];
        ac_y[i]  <= sh_y[i];
        ac_en[i] <= sh_en[i];
      end
    end
  end

  // Hit test with one extra bit so x+WIDTH / y+HEIGHT cannot wrap.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [11:0] h12, x12, xe12;
    logic [10:0] v11, y11, ye11;
    assign h12  = {1'b0, hcount_in};
    assign x12  = {1'b0, ac_x[g]};
    assign xe12 = x12 + 12'(WIDTH);
    assign v11  = {1'b0, vcount_in};
    assign y11  = {1'b0, ac_y[g]};
    assign ye11 = y11 + 11'(HEIGHT);
    assign hit_c[g] = ac_en[g]
                    && (h12 >= x12) && (h12 < xe12)
                    && (v11 >= y11) && (v11 < ye11);
    assign hoff_c[g] = hcount_in - ac_x[g];
    assign voff_c[g] = vcount_in - ac_y[g];
  end

  // Stage 1
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_s1 <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        hoff_s1[i] <= '0;
        voff_s1[i] <= '0;
      end
    end else begin
      hit_s1 <= hit_c;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        hoff_s1[i] <= hoff_c[i];
        voff_s1[i] <= voff_c[i];
      end
    end
  end

  // Lowest index wins: scan downward so lower hits overwrite.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_h   = '0;
    sel_v   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
        sel_h   = hoff_s1[i];
        sel_v   = voff_s1[i];
      end
    end
  end

  assign addr_full = 21'(sel_v) * 21'(WIDTH) + 21'(sel_h);

  // Stage 2
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      image_addr_out <= '0;
      in_sprite_out  <= 1'b0;
      sprite_idx_out <= '0;
    end else begin
      image_addr_out <= sel_hit ? addr_full[AW-1:0] : '0;
      in_sprite_out  <= sel_hit;
      sprite_idx_out <= sel_idx;
    end
  end

`ifdef SPRITE_COLLISION_DETECT_EN
  logic multi_hit;
  logic col_q;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hit = |(hit_s1 & (hit_s1 - NUM_SPRITES'(1)));

  // Set has priority over the per-frame clear.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)         col_q <= 1'b0;
    else if (multi_hit) col_q <= 1'b1;
    else if (commit)    col_q <= 1'b0;
  end

  assign collision_out = col_q;
`else
  assign collision_out = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: directed scenarios plus random traffic,
// checked against a frame-level model of placement, commit and hits.
module tb_sprite_scheduler;

  localparam int N = 4;
  localparam int W = 73;
  localparam int H = 9;
`ifdef SPRITE_COLLISION_DETECT_EN
  localparam bit COLDET = 1'b1;
`else
  localparam bit COLDET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        new_frame;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_idx;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic        cfg_en;
  logic [9:0]  image_addr;
  logic        in_sprite;
  logic [1:0]  sprite_idx;
  logic        collision;

  sprite_scheduler #(
    .NUM_SPRITES(N), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .new_frame_in  (new_frame),
    .cfg_valid_in  (cfg_valid),
    .cfg_ready_out (cfg_ready),
    .cfg_idx_in    (cfg_idx),
    .cfg_x_in      (cfg_x),
    .cfg_y_in      (cfg_y),
    .cfg_en_in     (cfg_en),
    .image_addr_out(image_addr),
    .in_sprite_out (in_sprite),
    .sprite_idx_out(sprite_idx),
    .collision_out (collision)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int sh_x [N];
  int sh_y [N];
  bit sh_en [N];
  int ac_x [N];
  int ac_y [N];
  bit ac_en [N];
  bit m_armed;
  bit p_hit, p_multi;
  int p_idx, p_addr;
  bit e_hit, e_col;
  int e_idx, e_addr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input int h, input int v,
                                 output bit hit, output int idx,
                                 output int addr, output bit multi);
    int cnt = 0;
    hit = 0; idx = 0; addr = 0;
    for (int i = 0; i < N; i++) begin
      if (ac_en[i] && h >= ac_x[i] && h < ac_x[i] + W &&
          v >= ac_y[i] && v < ac_y[i] + H) begin
        cnt++;
        if (!hit) begin
          hit  = 1;
          idx  = i;
          addr = (v - ac_y[i]) * W + (h - ac_x[i]);
        end
      end
    end
    multi = (cnt >= 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0;
    end
    m_armed = 1;
    p_hit = 0; p_multi = 0; p_idx = 0; p_addr = 0;
    e_hit = 0; e_col = 0; e_idx = 0; e_addr = 0;
  endfunction

  task automatic check_all(string ctx);
    chk({ctx, ".in_sprite"}, 32'(in_sprite), 32'(e_hit));
    chk({ctx, ".idx"}, 32'(sprite_idx), 32'(e_idx));
    chk({ctx, ".addr"}, 32'(image_addr), 32'(e_addr));
    chk({ctx, ".collision"}, 32'(collision), 32'(e_col));
    chk({ctx, ".ready"}, 32'(cfg_ready), 32'(m_armed));
  endtask

  task automatic cyc(int h, int v, bit nf, bit val,
                     int idx, int x, int y, bit en);
    bit nh, nm;
    int ni, na;
    hcount = 11'(h); vcount = 10'(v); new_frame = nf;
    cfg_valid = val; cfg_idx = 2'(idx);
    cfg_x = 11'(x); cfg_y = 10'(y); cfg_en = en;
    @(posedge clk);
    lookup(h, v, nh, ni, na, nm);
    e_hit = p_hit; e_idx = p_idx; e_addr = p_addr;
    if (!m_armed) e_col = 0;
    if (COLDET && p_multi) e_col = 1;
    p_hit = nh; p_idx = ni; p_addr = na; p_multi = nm;
    if (m_armed && val) begin
      sh_x[idx] = x; sh_y[idx] = y; sh_en[idx] = en;
    end else if (!m_armed) begin
      for (int i = 0; i < N; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i];
      end
    end
    m_armed = m_armed ? !nf : 1'b1;
    #1;
    check_all("cyc");
  endtask

  task automatic wr(int idx, int x, int y, bit en);
    cyc(0, 0, 0, 1, idx, x, y, en);
  endtask

  task automatic frame();
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("commit_ready_low", 32'(cfg_ready), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("commit_ready_back", 32'(cfg_ready), 32'd1);
  endtask

  task automatic query(int h, int v);
    cyc(h, v, 0, 0, 0, 0, 0, 0);
    cyc(h, v, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is raised between edges, with a write request pending
  // that must be dropped.
  task automatic do_reset();
    cfg_valid = 1; cfg_idx = 0; cfg_x = 11'd10;
    cfg_y = 10'd10; cfg_en = 1;
    rst = 1;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 0;
    cfg_valid = 0;
  endtask

  initial begin
    rst = 1; hcount = 0; vcount = 0; new_frame = 0;
    cfg_valid = 0; cfg_idx = 0; cfg_x = 0; cfg_y = 0; cfg_en = 0;
    model_reset();
    do_reset();

    // Single sprite at (100,50)
    wr(0, 100, 50, 1);
    frame();
    query(100, 50);
    chk("s0_origin_hit", 32'(in_sprite), 32'd1);
    chk("s0_origin_addr", 32'(image_addr), 32'd0);
    query(172, 58);
    chk("s0_corner_addr", 32'(image_addr), 32'd656);
    query(173, 58);
    chk("s0_right_miss", 32'(in_sprite), 32'd0);

    // Overlapping sprites 1 and 2
    wr(1, 200, 100, 1);
    wr(2, 200, 100, 1);
    frame();
    query(205, 102);
    chk("ovl_idx", 32'(sprite_idx), 32'd1);
    chk("ovl_addr", 32'(image_addr), 32'd151);
    chk("ovl_col", 32'(collision), 32'(COLDET));
    frame();
    chk("ovl_col_cleared", 32'(collision), 32'd0);

    // Shadow write is invisible until the next commit
    wr(0, 300, 50, 1);
    query(100, 50);
    chk("old_x_hit", 32'(in_sprite), 32'd1);
    query(300, 50);
    chk("new_x_pending", 32'(in_sprite), 32'd0);
    frame();
    query(300, 50);
    chk("new_x_hit", 32'(in_sprite), 32'd1);
    query(100, 50);
    chk("old_x_gone", 32'(in_sprite), 32'd0);

    // Write held across new_frame_in
    cyc(0, 0, 1, 1, 3, 400, 200, 1);
    chk("held_ready_low", 32'(cfg_ready), 32'd0);
    cyc(0, 0, 0, 1, 3, 500, 200, 1);
    chk("held_ready_high", 32'(cfg_ready), 32'd1);
    cyc(0, 0, 0, 1, 3, 500, 200, 1);
    query(400, 200);
    chk("held_in_commit", 32'(sprite_idx), 32'd3);
    chk("held_in_commit_hit", 32'(in_sprite), 32'd1);
    query(500, 200);
    chk("stalled_shadow_only", 32'(in_sprite), 32'd0);

    // Right-edge sprite must not wrap to column 0
    wr(1, 1270, 0, 1);
    frame();
    query(5, 0);
    chk("no_wrap", 32'(in_sprite), 32'd0);
    query(1275, 0);
    chk("edge_hit_addr", 32'(image_addr), 32'd5);

    // Reset mid-frame, then reset inside COMMIT
    cyc(1275, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst_mid_insprite", 32'(in_sprite), 32'd0);
    wr(2, 50, 20, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    do_reset();
    query(60, 25);
    chk("rst_commit_cleared", 32'(in_sprite), 32'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      bit nf, val, en;
      int h, v, idx, x, y;
      nf  = ($urandom_range(0, 19) == 0);
      val = ($urandom_range(0, 3) == 0);
      idx = $urandom_range(0, N - 1);
      x   = $urandom_range(0, 350);
      y   = $urandom_range(0, 200);
      en  = ($urandom_range(0, 3) != 0);
      h   = $urandom_range(0, 430);
      v   = $urandom_range(0, 215);
      if ($urandom_range(0, 15) == 0) x = $urandom_range(1200, 2047);
      cyc(h, v, nf, val, idx, x, y, en);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
